// File: rtl/pic8259_pkg.sv
// pic8259_pkg: shared definitions for the 8259A command-word sequencer.
//   - seq_state_e    : initialization / run state encoding
//   - bit indices    : ICW1/ICW4/OCW2/OCW3 field positions on the data bus
//   - OCW2 encodings : R/SL/EOI command codes (OCW2[7:5])
//   - is_icw1()      : ICW1 decode (A0=0, D4=1), legal from any state
package pic8259_pkg;

  typedef enum logic [2:0] {
    ST_UNINIT    = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } seq_state_e;

  // Command discrimination bits (A0=0 writes)
  localparam int BIT_D3   = 3;
  localparam int BIT_D4   = 4;

  // ICW1
  localparam int BIT_IC4  = 0;
  localparam int BIT_SNGL = 1;
  localparam int BIT_LTIM = 3;

  // ICW4
  localparam int BIT_UPM  = 0;
  localparam int BIT_AEOI = 1;
  localparam int BIT_MS   = 2;
  localparam int BIT_BUF  = 3;
  localparam int BIT_SFNM = 4;

  // OCW3
  localparam int BIT_RIS  = 0;
  localparam int BIT_RR   = 1;
  localparam int BIT_P    = 2;
  localparam int BIT_SMM  = 5;
  localparam int BIT_ESMM = 6;

  // OCW2[7:5] = {R, SL, EOI}
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SPEC_EOI     = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SPEC_EOI = 3'b111;

  function automatic logic is_icw1(input logic a0, input logic [7:0] d);
    return ~a0 & d[BIT_D4];
  endfunction

endpackage

// File: rtl/bus_strobe_sync_8259.sv
// bus_strobe_sync_8259: brings the CPU write bus into the clock domain,
// captures address/data while the write is active and flags a write event
// on the first cycle the write is no longer active.
//   clock, reset               : system clock, sync active-high reset
//   chip_select_n, write_enable_n, address, data_bus_in : raw CPU bus
//   wr_event                   : one-cycle write-complete indication
//   wr_addr, wr_data           : A0 / data captured during the write
module bus_strobe_sync_8259 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       chip_select_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic       wr_event,
  output logic       wr_addr,
  output logic [7:0] wr_data
);

  // {cs_n, we_n, a0, data}; strobes idle high so reset looks like "no write"
  localparam logic [10:0] BUS_IDLE = 11'b11_0_0000_0000;

  logic [10:0] bus_in;
  logic [10:0] bus_s;

  assign bus_in = {chip_select_n, write_enable_n, address, data_bus_in};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign bus_s = bus_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;

      always_comb begin
        sync_d[0] = bus_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      end

      always_ff @(posedge clock) begin
        if (reset) sync_q <= {SYNC_STAGES{BUS_IDLE}};
        else       sync_q <= sync_d;
      end

      assign bus_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic       active;
  logic       cap_vld_q, cap_vld_d;
  logic       addr_q, addr_d;
  logic [7:0] data_q, data_d;

  assign active = ~bus_s[10] & ~bus_s[9];

  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    // Flag tracks "active was high last cycle"; it drops on the event cycle,
    // so a strobe held across reset needs one sampled-low cycle to re-arm.
    cap_vld_d = active;
    if (active) begin
      addr_d = bus_s[8];
      data_d = bus_s[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cap_vld_q <= 1'b0;
      addr_q    <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      cap_vld_q <= cap_vld_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign wr_event = cap_vld_q & ~active;
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;

endmodule

// File: rtl/command_word_sequencer_8259.sv
// command_word_sequencer_8259: 8259A ICW1..ICW4 initialization sequencer and
// OCW1/2/3 router. All outputs are registered; *_valid, poll_request and
// sequence_error are one-cycle pulses aligned with the field updates.
//   clock, reset        : system clock, sync active-high reset
//   chip_select_n, write_enable_n, address, data_bus_in : CPU bus
//   init_done, level_triggered, single_mode, vector_base, cascade_config,
//   icw4_*              : initialization configuration
//   interrupt_mask      : IMR (OCW1)
//   ocw2_valid/cmd/level: OCW2 command pulse and fields
//   ocw3_valid, special_mask_mode, poll_request, read_isr_select : OCW3
//   sequence_error      : pulse for an ignored, illegal write
module command_word_sequencer_8259
  import pic8259_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       chip_select_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic       init_done,
  output logic       level_triggered,
  output logic       single_mode,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_config,
  output logic       icw4_upm,
  output logic       icw4_aeoi,
  output logic       icw4_buf,
  output logic       icw4_master,
  output logic       icw4_sfnm,
  output logic [7:0] interrupt_mask,
  output logic       ocw2_valid,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       ocw3_valid,
  output logic       special_mask_mode,
  output logic       poll_request,
  output logic       read_isr_select,
  output logic       sequence_error
);

  logic       ev;
  logic       ev_a0;
  logic [7:0] ev_d;

  bus_strobe_sync_8259 #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock          (clock),
    .reset          (reset),
    .chip_select_n  (chip_select_n),
    .write_enable_n (write_enable_n),
    .address        (address),
    .data_bus_in    (data_bus_in),
    .wr_event       (ev),
    .wr_addr        (ev_a0),
    .wr_data        (ev_d)
  );

  logic [2:0] state_q, state_d;
  logic       init_done_q, init_done_d;
  logic       ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
  logic [4:0] vb_q, vb_d;
  logic [7:0] cas_q, cas_d;
  logic [4:0] icw4_q, icw4_d;   // ICW4[4:0] as written
  logic [7:0] imr_q, imr_d;
  logic       o2v_q, o2v_d;
  logic [2:0] o2c_q, o2c_d, o2l_q, o2l_d;
  logic       o3v_q, o3v_d;
  logic       smm_q, smm_d, poll_q, poll_d, ris_q, ris_d;
  logic       serr_q, serr_d;

  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    ltim_d      = ltim_q;
    sngl_d      = sngl_q;
    ic4_d       = ic4_q;
    vb_d        = vb_q;
    cas_d       = cas_q;
    icw4_d      = icw4_q;
    imr_d       = imr_q;
    o2c_d       = o2c_q;
    o2l_d       = o2l_q;
    smm_d       = smm_q;
    ris_d       = ris_q;
    o2v_d       = 1'b0;
    o3v_d       = 1'b0;
    poll_d      = 1'b0;
    serr_d      = 1'b0;

    if (ev) begin
      if (is_icw1(ev_a0, ev_d)) begin
        // ICW1 restarts from any state, including mid-sequence
        ltim_d      = ev_d[BIT_LTIM];
        sngl_d      = ev_d[BIT_SNGL];
        ic4_d       = ev_d[BIT_IC4];
        imr_d       = 8'h00;
        smm_d       = 1'b0;
        ris_d       = 1'b0;
        init_done_d = 1'b0;
        if (!ev_d[BIT_IC4]) icw4_d = 5'b0;
        state_d     = ST_WAIT_ICW2;
      end else begin
        case (state_q)
          ST_WAIT_ICW2: begin
            if (ev_a0) begin
              vb_d = ev_d[7:3];
              if (!sngl_q)    state_d = ST_WAIT_ICW3;
              else if (ic4_q) state_d = ST_WAIT_ICW4;
              else begin
                state_d     = ST_READY;
                init_done_d = 1'b1;
              end
            end else serr_d = 1'b1;
          end
          ST_WAIT_ICW3: begin
            if (ev_a0) begin
              cas_d = ev_d;
              if (ic4_q) state_d = ST_WAIT_ICW4;
              else begin
                state_d     = ST_READY;
                init_done_d = 1'b1;
              end
            end else serr_d = 1'b1;
          end
          ST_WAIT_ICW4: begin
            if (ev_a0) begin
              icw4_d      = ev_d[4:0];
              state_d     = ST_READY;
              init_done_d = 1'b1;
            end else serr_d = 1'b1;
          end
          ST_READY: begin
            if (ev_a0) imr_d = ev_d;
            else if (!ev_d[BIT_D3]) begin
              o2v_d = 1'b1;
              o2c_d = ev_d[7:5];
              o2l_d = ev_d[2:0];
            end else begin
              o3v_d  = 1'b1;
              poll_d = ev_d[BIT_P];
              if (ev_d[BIT_RR])   ris_d = ev_d[BIT_RIS];
              if (ev_d[BIT_ESMM]) smm_d = ev_d[BIT_SMM];
            end
          end
          ST_UNINIT: serr_d = 1'b1;
          default:   state_d = ST_UNINIT;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_UNINIT;
      init_done_q <= 1'b0;
      ltim_q      <= 1'b0;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      vb_q        <= 5'h00;
      cas_q       <= 8'h00;
      icw4_q      <= 5'h00;
      imr_q       <= 8'hFF;
      o2v_q       <= 1'b0;
      o2c_q       <= 3'b000;
      o2l_q       <= 3'b000;
      o3v_q       <= 1'b0;
      smm_q       <= 1'b0;
      poll_q      <= 1'b0;
      ris_q       <= 1'b0;
      serr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      ltim_q      <= ltim_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      vb_q        <= vb_d;
      cas_q       <= cas_d;
      icw4_q      <= icw4_d;
      imr_q       <= imr_d;
      o2v_q       <= o2v_d;
      o2c_q       <= o2c_d;
      o2l_q       <= o2l_d;
      o3v_q       <= o3v_d;
      smm_q       <= smm_d;
      poll_q      <= poll_d;
      ris_q       <= ris_d;
      serr_q      <= serr_d;
    end
  end

  assign init_done         = init_done_q;
  assign level_triggered   = ltim_q;
  assign single_mode       = sngl_q;
  assign vector_base       = vb_q;
  assign cascade_config    = cas_q;
  assign icw4_upm          = icw4_q[BIT_UPM];
  assign icw4_aeoi         = icw4_q[BIT_AEOI];
  assign icw4_master       = icw4_q[BIT_MS];
  assign icw4_buf          = icw4_q[BIT_BUF];
  assign icw4_sfnm         = icw4_q[BIT_SFNM];
  assign interrupt_mask    = imr_q;
  assign ocw2_valid        = o2v_q;
  assign ocw2_cmd          = o2c_q;
  assign ocw2_level        = o2l_q;
  assign ocw3_valid        = o3v_q;
  assign special_mask_mode = smm_q;
  assign poll_request      = poll_q;
  assign read_isr_select   = ris_q;
  assign sequence_error    = serr_q;

endmodule

// File: doc/command_word_sequencer_8259.md
# command_word_sequencer_8259

Clocked command-word sequencer for the 8259A core. It samples the CPU write strobe, address and data bus, detects completed writes, and runs the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence. It then routes OCW1/OCW2/OCW3 writes. Its registered configuration and one-cycle command pulses feed the priority resolver, IMR/ISR logic and cascade logic.

## Interface
- SYNC_STAGES, 2, synchronizer flops on chip_select_n/write_enable_n/address/data_bus_in (0 = inputs already in clock domain)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- chip_select_n  in  1  CPU chip select, active low
- write_enable_n  in  1  CPU write strobe, active low
- address  in  1  A0
- data_bus_in  in  8  CPU data
- init_done  out  1  initialization sequence complete
- level_triggered  out  1  ICW1.LTIM
- single_mode  out  1  ICW1.SNGL
- vector_base  out  5  ICW2[7:3]
- cascade_config  out  8  ICW3 byte
- icw4_upm, icw4_aeoi, icw4_buf, icw4_master, icw4_sfnm  out  1 each  ICW4 bits 0,1,3,2,4
- interrupt_mask  out  8  OCW1 (IMR)
- ocw2_valid  out  1  one-cycle pulse on OCW2 write
- ocw2_cmd  out  3  OCW2[7:5] (R, SL, EOI)
- ocw2_level  out  3  OCW2[2:0]
- ocw3_valid  out  1  one-cycle pulse on OCW3 write
- special_mask_mode  out  1  sticky, set/cleared by OCW3 ESMM/SMM
- poll_request  out  1  one-cycle pulse, OCW3.P
- read_isr_select  out  1  sticky, 1 = ISR, 0 = IRR (OCW3 RR/RIS)
- sequence_error  out  1  one-cycle pulse, illegal write ignored

## Operation
- Write capture: active = ~chip_select_n & ~write_enable_n after sync. Each cycle active is high, address and data are captured. A write event fires on the first cycle active is low after having been high. An event uses the last captured address/data. Other cycles produce no event.
- FSM states: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- ICW1 = event with A0=0, D4=1, from any state:
  - latch LTIM, SNGL, IC4
  - clear interrupt_mask to 8'h00, special_mask_mode, read_isr_select and init_done
  - clear ICW4 fields when IC4=0
  - go to WAIT_ICW2
- WAIT_ICW2, A0=1: latch vector_base. Then go to WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW3, A0=1: latch cascade_config. Then go to WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW4, A0=1: latch the ICW4 bits, then go to READY.
- Entering READY sets init_done.
- In any WAIT state, an A0=0, D4=0 event is ignored and pulses sequence_error. The state is unchanged.
- READY:
  - A0=1: OCW1, load interrupt_mask.
  - A0=0, D4=0, D3=0: OCW2, pulse ocw2_valid with fields.
  - A0=0, D4=0, D3=1: OCW3, pulse ocw3_valid.
    - D1=1 (RR): load read_isr_select ← D0 (RIS).
    - D6=1 (ESMM): load special_mask_mode ← D5 (SMM).
    - D2=1: pulse poll_request.
- UNINIT: any non-ICW1 event is ignored and pulses sequence_error.
- Reset values:
  - state UNINIT; init_done 0
  - all config fields 0; interrupt_mask 8'hFF
  - all pulses 0; captured address/data 0; capture-valid flag 0

## Timing
- Latency: a write_enable_n rising edge produces updated outputs and pulses SYNC_STAGES+1 clock edges later.
- All outputs are registered. Pulses are high for exactly one cycle, coincident with the updated fields.
- Host constraint: active held ≥ SYNC_STAGES+2 cycles, with data/address stable throughout. Events must be ≥ 2 cycles apart.
- chip_select_n rising before write_enable_n also ends active and fires an event (write-end semantics).
- Reset mid-sequence returns to UNINIT and clears the capture-valid flag. A strobe already low at reset release fires an event only after being sampled low at least once post-reset.
- Reset has priority over a simultaneous event.
- ICW1 arriving mid-sequence restarts cleanly. Back-to-back ICW1 is legal.

## Structure
- Package pic8259_pkg:
  - state enum
  - ICW/OCW bit-index constants (D3, D4, LTIM, SNGL, IC4, RR, RIS, P, ESMM, SMM)
  - OCW2 command encodings
- Sub-module bus_strobe_sync_8259: synchronizer, capture registers and write-event detect. Outputs event, addr, data.
- Parent holds the FSM and config registers.

## Test plan
- Single mode, no ICW4: ICW1 8'h12, ICW2 8'h40 → READY; vector_base 5'h08, interrupt_mask 8'h00, cascade_config 0.
- Cascade with ICW4: ICW1 8'h11, ICW2 8'h20, ICW3 8'h04, ICW4 8'h03 → cascade_config 8'h04, icw4_aeoi 1, icw4_upm 1, init_done 1 after the fourth event only.
- In READY:
  - OCW1 8'hA5 → interrupt_mask 8'hA5.
  - OCW2 8'h63 (specific EOI, level 3) → ocw2_valid pulse 1 cycle, ocw2_cmd 3'b011, ocw2_level 3.
- OCW3 8'h6B → special_mask_mode 1, read_isr_select 1. Then OCW3 8'h0C → poll_request pulse; special_mask_mode stays 1.
- Error and restart: after ICW1, write A0=0 data 8'h20 → sequence_error pulse, still WAIT_ICW2. A new ICW1 mid-ICW3 restarts the sequence.
- Reset mid-sequence with write_enable_n held low → UNINIT, mask 8'hFF, no spurious event. Exactly one event follows once the strobe is sampled low and then released.
